instruction_fetch: RTL
======================

# instruction_fetch

Instruction fetch stage for the 16-bit CPU. Holds the program counter (PC) and instruction register (IR), issues read requests to instruction memory, and hands the fetched word to the control unit. It sits directly upstream of the control unit: it obeys that unit's PC clear, PC increment and IR load commands, and supplies the IR it decodes.

## Interface
Parameters:
- PC_WIDTH, 7, PC and instruction-memory address width; memory depth is 2^PC_WIDTH words.
- INSTR_WIDTH, 16, instruction word width; bits [15:12] are the opcode.
- TIMEOUT, 15, maximum number of WAIT cycles without IM_VALID before faulting; range 1..255.

Ports:
- Clock  in  1  the single clock; all state updates on its rising edge.
- Reset  in  1  synchronous, active-low reset.
- PC_CLR  in  1  clears the PC to 0 and aborts any fetch or fault.
- PC_IC  in  1  increments the PC by 1.
- IR_LD  in  1  starts a fetch from the current PC into the IR.
- IM_ADDR  out  PC_WIDTH  instruction-memory read address, latched at fetch start.
- IM_RD  out  1  instruction-memory read request, level, held until response.
- IM_DATA  in  INSTR_WIDTH  instruction-memory read data, valid only with IM_VALID.
- IM_VALID  in  1  instruction-memory response strobe.
- PC  out  PC_WIDTH  current program counter.
- IR  out  INSTR_WIDTH  instruction register, goes to the control unit.
- OPCODE  out  4  IR[15:12], combinational from the IR.
- FETCH_BUSY  out  1  high while in WAIT.
- FETCH_DONE  out  1  one-cycle pulse; the IR was updated at the preceding edge.
- FETCH_ERR  out  1  sticky timeout flag; high in FAULT.

## Operation
- States: IDLE, WAIT, FAULT.
- Reset (Reset=0 at an edge): state=IDLE. PC=0, IR=0, IM_ADDR=0, IM_RD=0, FETCH_BUSY=0, FETCH_DONE=0, FETCH_ERR=0, timeout counter=0.
- IDLE + IR_LD: IM_ADDR<=PC (value before any same-cycle increment), IM_RD<=1, counter<=0, go to WAIT.
- WAIT + IM_VALID: IR<=IM_DATA, IM_RD<=0, FETCH_DONE<=1, go to IDLE.
- WAIT, no IM_VALID: counter increments. When counter reaches TIMEOUT: IM_RD<=0, FETCH_ERR<=1, go to FAULT. If IM_VALID arrives on that same cycle, the valid wins and there is no fault.
- FAULT: IR_LD is ignored. The only exits are PC_CLR, which goes to IDLE and clears FETCH_ERR, or Reset.
- IM_VALID in IDLE or FAULT is ignored; the IR is unchanged.
- IR_LD in WAIT or FAULT is ignored. There is no queueing.
- PC update priority:
  - PC_CLR first: PC<=0.
  - Otherwise PC_IC: PC<=PC+1 modulo 2^PC_WIDTH, so all-ones wraps to 0 with no flag.
  - PC_IC is legal in any state. It never changes an in-flight IM_ADDR.
- PC_CLR during WAIT aborts the fetch:
  - IM_RD<=0 and state goes to IDLE.
  - IR is unchanged and no FETCH_DONE is generated.
  - A late IM_VALID is dropped.
- PC_CLR and IR_LD in the same cycle: the clear wins and no fetch starts.
- IR_LD and PC_IC in the same cycle in IDLE: the fetch uses the old PC, and the PC increments.
- Reset mid-WAIT: all outputs take their reset values at that edge, and a subsequent IM_VALID is ignored.

## Timing
- IR_LD high in cycle n (IDLE) → IM_RD=1 and IM_ADDR valid from cycle n+1.
- IM_VALID may be high in any WAIT cycle, including the first (n+1).
- IM_VALID in cycle k → IR holds the new value and FETCH_DONE=1 in cycle k+1. Minimum IR_LD-to-IR latency is 2 cycles.
- IM_RD stays high for every WAIT cycle and deasserts in the cycle after IM_VALID, timeout, or PC_CLR.
- IM_ADDR holds its value from fetch start until the next fetch start.
- The memory must keep IM_DATA stable only during the IM_VALID cycle.
- A new IR_LD is accepted in the FETCH_DONE cycle, giving back-to-back fetches every 2 cycles at zero memory wait.
- Timeout: with no response, FETCH_ERR=1 in cycle n+1+TIMEOUT.
- FETCH_BUSY equals (state==WAIT), registered together with the state.
- All outputs are registered except OPCODE.

## Test plan
- Reset, then PC_IC for 3 cycles → PC=3. Then IR_LD with memory answering 0x1234 on the first WAIT cycle → IR=0x1234, OPCODE=0x1, FETCH_DONE pulses 1 cycle, IM_ADDR=3.
- IR_LD with PC_IC in the same cycle at PC=5, memory latency 3 cycles → IM_ADDR=5, PC=6, IM_RD high exactly 3 cycles, IR loaded with word 5.
- PC=127, PC_IC → PC=0. PC_IC together with PC_CLR → PC=0.
- IR_LD, no IM_VALID for 15 cycles (TIMEOUT=15) → FETCH_ERR=1 and IM_RD=0. A later IR_LD is ignored. PC_CLR → FETCH_ERR=0, state IDLE, next fetch succeeds.
- IR_LD, PC_CLR on the second WAIT cycle, IM_VALID with 0xBEEF on the next cycle → IR unchanged, no FETCH_DONE, PC=0.
- Reset asserted mid-WAIT with IM_VALID on the following cycle → IR=0, IM_RD=0, FETCH_BUSY=0, no FETCH_DONE.

Source files
------------

// File: rtl/instruction_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instruction_fetch                                                    |
// | PC/IR holder issuing timed-out instruction-memory read requests.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module instruction_fetch #(
  parameter int PC_WIDTH    = 7,
  parameter int INSTR_WIDTH = 16,
  parameter int TIMEOUT     = 15
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   PC_CLR,
  input  logic                   PC_IC,
  input  logic                   IR_LD,
  output logic [PC_WIDTH-1:0]    IM_ADDR,
  output logic                   IM_RD,
  input  logic [INSTR_WIDTH-1:0] IM_DATA,
  input  logic                   IM_VALID,
  output logic [PC_WIDTH-1:0]    PC,
  output logic [INSTR_WIDTH-1:0] IR,
  output logic [3:0]             OPCODE,
  output logic                   FETCH_BUSY,
  output logic                   FETCH_DONE,
  output logic                   FETCH_ERR
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [7:0]          c_tmo_last = 8'(TIMEOUT - 1);
  localparam logic [PC_WIDTH-1:0] c_pc_one   = PC_WIDTH'(1);

  state_t                 r_state;
  logic [7:0]             r_tmo_cnt;
  logic [PC_WIDTH-1:0]    r_pc;
  logic [PC_WIDTH-1:0]    r_im_addr;
  logic [INSTR_WIDTH-1:0] r_ir;
  logic                   r_im_rd;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_err;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state   <= IDLE;
      r_tmo_cnt <= '0;
      r_pc      <= '0;
      r_im_addr <= '0;
      r_ir      <= '0;
      r_im_rd   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (PC_CLR)
        r_pc <= '0;
      else if (PC_IC)
        r_pc <= r_pc + c_pc_one;

      case (r_state)
        IDLE: begin
          if (IR_LD && !PC_CLR) begin
            r_im_addr <= r_pc;
            r_im_rd   <= 1'b1;
            r_tmo_cnt <= '0;
            r_busy    <= 1'b1;
            r_state   <= WAIT;
          end
        end
        WAIT: begin
          if (PC_CLR) begin
            r_im_rd <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (IM_VALID) begin
            r_ir    <= IM_DATA;
            r_im_rd <= 1'b0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (r_tmo_cnt == c_tmo_last) begin
            // Final permitted wait cycle with no response: fault at this edge.
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
            r_im_rd   <= 1'b0;
            r_err     <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= FAULT;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
          end
        end
        FAULT: begin
          if (PC_CLR) begin
            r_err   <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_im_rd <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign PC         = r_pc;
  assign IR         = r_ir;
  assign IM_ADDR    = r_im_addr;
  assign IM_RD      = r_im_rd;
  assign FETCH_BUSY = r_busy;
  assign FETCH_DONE = r_done;
  assign FETCH_ERR  = r_err;
  assign OPCODE     = r_ir[INSTR_WIDTH-1 -: 4];

endmodule
`default_nettype wire
